// File: rtl/phys_reg_free_list_if.sv
// Free-list handshake bundle between COMMIT/rename (master) and the free list (slave).
//  master: drives push/pop requests, recover pulse and the retirement RAT;
//          observes pop ID/valid, empty, count, busy and overflow.
//  slave : the free list itself, the mirror image of master.
interface phys_reg_free_list_if #(
    parameter int unsigned PREG_WIDTH = 6,
    parameter int unsigned ARCH_REGS  = 32
);
    logic                              tFL_pushReq_IN;
    logic [PREG_WIDTH-1:0]             tFL_pushId_IN;
    logic                              tFL_popReq_IN;
    logic [PREG_WIDTH-1:0]             fFL_popId_OUT;
    logic                              fFL_popValid_OUT;
    logic                              fFL_empty_OUT;
    logic [PREG_WIDTH:0]               fFL_count_OUT;
    logic                              tFL_recover_IN;
    logic [ARCH_REGS*PREG_WIDTH-1:0]   tFL_retRat_IN;
    logic                              fFL_busy_OUT;
    logic                              fFL_overflow_OUT;

    modport master (
        output tFL_pushReq_IN, tFL_pushId_IN, tFL_popReq_IN, tFL_recover_IN, tFL_retRat_IN,
        input  fFL_popId_OUT, fFL_popValid_OUT, fFL_empty_OUT, fFL_count_OUT, fFL_busy_OUT,
               fFL_overflow_OUT
    );

    modport slave (
        input  tFL_pushReq_IN, tFL_pushId_IN, tFL_popReq_IN, tFL_recover_IN, tFL_retRat_IN,
        output fFL_popId_OUT, fFL_popValid_OUT, fFL_empty_OUT, fFL_count_OUT, fFL_busy_OUT,
               fFL_overflow_OUT
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register IDs.
//  Rename pops the head ID, COMMIT pushes freed IDs at the tail. A recover pulse runs a
//  SNAP/SCAN rebuild that refills the list, in ascending order, with every ID not named in
//  the retirement RAT snapshot.
// Ports:
//  CLK    : clock, all state on posedge
//  RESET  : synchronous active-low reset
//  FREEZE : hold every piece of state, including the recovery FSM
//  fl     : slave side of phys_reg_free_list_if (push/pop/recover/status)
module phys_reg_free_list #(
    parameter int unsigned PHYS_REGS  = 64,
    parameter int unsigned PREG_WIDTH = 6,
    parameter int unsigned ARCH_REGS  = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FREEZE,
    phys_reg_free_list_if.slave   fl
);

    typedef enum logic [1:0] {StIdle, StSnap, StScan} state_e;

    localparam logic [PREG_WIDTH-1:0] LastPtr   = PREG_WIDTH'(PHYS_REGS - 1);
    localparam logic [PREG_WIDTH:0]   FullCount = (PREG_WIDTH + 1)'(PHYS_REGS);

    state_e                          state_q, state_d;
    logic [PREG_WIDTH-1:0]           entries_q [PHYS_REGS];
    logic [PREG_WIDTH-1:0]           entries_d [PHYS_REGS];
    logic [PREG_WIDTH-1:0]           head_q, head_d;
    logic [PREG_WIDTH-1:0]           tail_q, tail_d;
    logic [PREG_WIDTH-1:0]           idx_q, idx_d;
    logic [PREG_WIDTH:0]             count_q, count_d;
    logic                            overflow_q, overflow_d;
    logic [ARCH_REGS*PREG_WIDTH-1:0] snap_q, snap_d;

    logic busy;
    logic pop_valid;
    logic pop_grant;
    logic push_ok;
    logic idx_mapped;

    function automatic logic [PREG_WIDTH-1:0] inc_ptr(input logic [PREG_WIDTH-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + 1'b1;
    endfunction

    assign busy      = (state_q != StIdle);
    assign pop_valid = !busy && (count_q != '0);

    // Is the scan index currently held by any architectural register in the snapshot?
    always_comb begin
        idx_mapped = 1'b0;
        for (int unsigned k = 0; k < ARCH_REGS; k++) begin
            if (snap_q[k*PREG_WIDTH +: PREG_WIDTH] == idx_q) begin
                idx_mapped = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        entries_d  = entries_q;
        head_d     = head_q;
        tail_d     = tail_q;
        idx_d      = idx_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        snap_d     = snap_q;
        pop_grant  = 1'b0;
        push_ok    = 1'b0;

        unique case (state_q)
            StIdle: begin
                pop_grant = fl.tFL_popReq_IN && pop_valid;
                push_ok   = fl.tFL_pushReq_IN && (count_q < FullCount);
                if (push_ok) begin
                    entries_d[tail_q] = fl.tFL_pushId_IN;
                    tail_d            = inc_ptr(tail_q);
                end else if (fl.tFL_pushReq_IN) begin
                    overflow_d = 1'b1;
                end
                if (pop_grant) begin
                    head_d = inc_ptr(head_q);
                end
                count_d = count_q + (PREG_WIDTH + 1)'(push_ok) - (PREG_WIDTH + 1)'(pop_grant);
            end
            StSnap: begin
                snap_d  = fl.tFL_retRat_IN;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                idx_d   = '0;
                state_d = StScan;
            end
            StScan: begin
                if (!idx_mapped) begin
                    entries_d[tail_q] = idx_q;
                    tail_d            = inc_ptr(tail_q);
                    count_d           = count_q + 1'b1;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LastPtr) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A recover pulse always (re)starts the rebuild; in IDLE the push/pop above still apply.
        if (fl.tFL_recover_IN) begin
            state_d = StSnap;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= StIdle;
            head_q     <= '0;
            tail_q     <= PREG_WIDTH'(PHYS_REGS - ARCH_REGS);
            idx_q      <= '0;
            count_q    <= (PREG_WIDTH + 1)'(PHYS_REGS - ARCH_REGS);
            overflow_q <= 1'b0;
            snap_q     <= '0;
            for (int unsigned i = 0; i < PHYS_REGS; i++) begin
                entries_q[i] <= (i < PHYS_REGS - ARCH_REGS) ? PREG_WIDTH'(ARCH_REGS + i) : '0;
            end
        end else if (!FREEZE) begin
            state_q    <= state_d;
            entries_q  <= entries_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            snap_q     <= snap_d;
        end
    end

    assign fl.fFL_popId_OUT    = entries_q[head_q];
    assign fl.fFL_popValid_OUT = pop_valid;
    assign fl.fFL_empty_OUT    = (count_q == '0);
    assign fl.fFL_count_OUT    = count_q;
    assign fl.fFL_busy_OUT     = busy;
    assign fl.fFL_overflow_OUT = overflow_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
module tb_phys_reg_free_list;
    localparam int unsigned PR = 64;
    localparam int unsigned PW = 6;
    localparam int unsigned AR = 32;

    typedef struct {
        logic          push;
        logic [PW-1:0] pid;
        logic          pop;
        logic          rec;
        int            e_count;
        int            e_id;     // -1: head ID not checked
        logic          e_valid;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic freeze;

    always #5 clk = ~clk;

    phys_reg_free_list_if #(.PREG_WIDTH(PW), .ARCH_REGS(AR)) fl_if ();

    phys_reg_free_list #(
        .PHYS_REGS (PR),
        .PREG_WIDTH(PW),
        .ARCH_REGS (AR)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .FREEZE(freeze),
        .fl    (fl_if)
    );

    // Reference model: a plain queue plus a busy-cycle counter.
    logic [PW-1:0]    m_fl[$];
    logic [PW-1:0]    exp_q[$];
    int               m_busy;
    logic             m_ovf;
    logic [AR*PW-1:0] m_snap;
    int               n_checks = 0;
    int               n_pass = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_fl.delete();
        for (int i = 0; i < 32; i++) m_fl.push_back(PW'(32 + i));
        m_busy = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_rebuild();
        logic hit;
        m_fl.delete();
        for (int id = 0; id < int'(PR); id++) begin
            hit = 1'b0;
            for (int k = 0; k < int'(AR); k++) begin
                if (int'(m_snap[k*PW +: PW]) == id) hit = 1'b1;
            end
            if (!hit) m_fl.push_back(PW'(id));
        end
    endtask

    task automatic model_edge(input logic push, input logic [PW-1:0] pid, input logic pop,
                              input logic rec, input logic [AR*PW-1:0] rat);
        int sz;
        if (!rst_n) begin
            model_reset();
        end else if (!freeze) begin
            if (m_busy == 0) begin
                sz = m_fl.size();
                if (pop && sz != 0) void'(m_fl.pop_front());
                if (push) begin
                    if (sz < int'(PR)) m_fl.push_back(pid);
                    else m_ovf = 1'b1;
                end
                if (rec) m_busy = PR + 1;
            end else begin
                if (m_busy == int'(PR) + 1) m_snap = rat;
                if (rec) m_busy = PR + 1;
                else begin
                    m_busy--;
                    if (m_busy == 0) model_rebuild();
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("busy", int'(fl_if.fFL_busy_OUT), int'(m_busy != 0));
        check("overflow", int'(fl_if.fFL_overflow_OUT), int'(m_ovf));
        if (m_busy == 0) begin
            check("count", int'(fl_if.fFL_count_OUT), m_fl.size());
            check("empty", int'(fl_if.fFL_empty_OUT), int'(m_fl.size() == 0));
            check("pop_valid", int'(fl_if.fFL_popValid_OUT), int'(m_fl.size() != 0));
            if (m_fl.size() != 0) check("head_id", int'(fl_if.fFL_popId_OUT), int'(m_fl[0]));
        end else begin
            check("pop_valid_busy", int'(fl_if.fFL_popValid_OUT), 0);
        end
    endtask

    // Drive one cycle's inputs (at posedge+1), then compare settled outputs before the edge.
    task automatic drive_check(input logic push, input logic [PW-1:0] pid, input logic pop,
                               input logic rec);
        fl_if.tFL_pushReq_IN = push;
        fl_if.tFL_pushId_IN  = pid;
        fl_if.tFL_popReq_IN  = pop;
        fl_if.tFL_recover_IN = rec;
        #1;
        check_outputs();
        if (rst_n && !freeze && m_busy == 0 && pop && m_fl.size() != 0) exp_q.push_back(m_fl[0]);
        while (exp_q.size() != 0) check("sb_pop_id", int'(fl_if.fFL_popId_OUT), int'(exp_q.pop_front()));
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge(fl_if.tFL_pushReq_IN, fl_if.tFL_pushId_IN, fl_if.tFL_popReq_IN,
                   fl_if.tFL_recover_IN, fl_if.tFL_retRat_IN);
        #1;
    endtask

    task automatic tick(input logic push, input logic [PW-1:0] pid, input logic pop,
                        input logic rec);
        drive_check(push, pid, pop, rec);
        edge_step();
    endtask

    task automatic run_vec(input vec_t v, input string name);
        drive_check(v.push, v.pid, v.pop, v.rec);
        check({name, "_count"}, int'(fl_if.fFL_count_OUT), v.e_count);
        check({name, "_valid"}, int'(fl_if.fFL_popValid_OUT), int'(v.e_valid));
        if (v.e_id >= 0) check({name, "_id"}, int'(fl_if.fFL_popId_OUT), v.e_id);
        edge_step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    // Counts cycles with busy high, pushing and popping throughout; bounded.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (fl_if.fFL_busy_OUT !== 1'b1) break;
            n++;
            tick(1'b1, PW'(i), 1'b1, 1'b0);
        end
    endtask

    initial begin
        vec_t          t1[4];
        vec_t          t3[2];
        int            n;
        int            seq5[4];
        logic [PW-1:0] rat_map[AR];

        t1[0] = '{1'b0, 6'd0, 1'b1, 1'b0, 32, 32, 1'b1};
        t1[1] = '{1'b0, 6'd0, 1'b1, 1'b0, 31, 33, 1'b1};
        t1[2] = '{1'b0, 6'd0, 1'b1, 1'b0, 30, 34, 1'b1};
        t1[3] = '{1'b0, 6'd0, 1'b0, 1'b0, 29, 35, 1'b1};
        t3[0] = '{1'b1, 6'd5, 1'b1, 1'b0, 0, -1, 1'b0};
        t3[1] = '{1'b0, 6'd0, 1'b0, 1'b0, 1, 5, 1'b1};
        seq5  = '{2, 3, 34, 35};

        fl_if.tFL_pushReq_IN = 1'b0;
        fl_if.tFL_pushId_IN  = '0;
        fl_if.tFL_popReq_IN  = 1'b0;
        fl_if.tFL_recover_IN = 1'b0;
        fl_if.tFL_retRat_IN  = '0;
        freeze = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;

        // 1: three pops from reset
        for (int i = 0; i < 4; i++) run_vec(t1[i], "t1");

        // 2: drain the remaining 29, then a popReq on an empty list
        for (int i = 0; i < 29; i++) tick(1'b0, '0, 1'b1, 1'b0);
        check("t2_empty", int'(fl_if.fFL_empty_OUT), 1);
        tick(1'b0, '0, 1'b1, 1'b0);
        check("t2_count_after_pop", int'(fl_if.fFL_count_OUT), 0);
        check("t2_valid_after_pop", int'(fl_if.fFL_popValid_OUT), 0);

        // 3: push+pop on empty list: push enters, pop not granted
        for (int i = 0; i < 2; i++) run_vec(t3[i], "t3");

        // 4: 40 simultaneous push/pop cycles so the tail wraps, then drain in FIFO order
        do_reset();
        for (int i = 0; i < 40; i++) tick(1'b1, PW'((i * 7 + 3) % 64), 1'b1, 1'b0);
        check("t4_count_back", int'(fl_if.fFL_count_OUT), 32);
        for (int i = 0; i < 32; i++) tick(1'b1, PW'(i + 20), 1'b0, 1'b0);
        check("t4_full_count", int'(fl_if.fFL_count_OUT), 64);
        tick(1'b1, 6'd9, 1'b1, 1'b0);
        check("t4_overflow", int'(fl_if.fFL_overflow_OUT), 1);
        check("t4_count_full_pushpop", int'(fl_if.fFL_count_OUT), 63);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1, 6'd1, 1'b1, 1'b1);
        freeze = 1'b0;
        check("t4_freeze_count", int'(fl_if.fFL_count_OUT), 63);
        for (int i = 0; i < 64; i++) tick(1'b0, '0, 1'b1, 1'b0);

        // 5: recovery. arch0/1 -> 32/33, arch2/3 hold phys 0/1, the rest identity,
        // so the rebuilt list starts 2,3,34,35.
        do_reset();
        tick(1'b0, '0, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < int'(AR); k++) rat_map[k] = PW'(k);
        rat_map[0] = 6'd32;
        rat_map[1] = 6'd33;
        rat_map[2] = 6'd0;
        rat_map[3] = 6'd1;
        for (int k = 0; k < int'(AR); k++) fl_if.tFL_retRat_IN[(AR-1-k)*PW +: PW] = rat_map[k];
        tick(1'b0, '0, 1'b0, 1'b1);
        count_busy(n);
        check("t5_busy_cycles", n, 65);
        check("t5_count", int'(fl_if.fFL_count_OUT), 32);
        for (int i = 0; i < 4; i++) begin
            drive_check(1'b0, '0, 1'b1, 1'b0);
            check("t5_pop_seq", int'(fl_if.fFL_popId_OUT), seq5[i]);
            edge_step();
        end

        // 6: set overflow, restart recovery mid-SCAN, then reset mid-SCAN
        for (int i = 0; i < 36; i++) tick(1'b1, PW'(i), 1'b0, 1'b0);
        tick(1'b1, 6'd7, 1'b0, 1'b0);
        check("t6_overflow_set", int'(fl_if.fFL_overflow_OUT), 1);
        for (int k = 0; k < int'(AR); k++) fl_if.tFL_retRat_IN[(AR-1-k)*PW +: PW] = PW'(k + 10);
        tick(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 21; i++) tick(1'b0, '0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b1);
        count_busy(n);
        check("t6_restart_busy_cycles", n, 65);
        check("t6_count", int'(fl_if.fFL_count_OUT), 32);
        check("t6_head", int'(fl_if.fFL_popId_OUT), 0);
        check("t6_overflow_kept", int'(fl_if.fFL_overflow_OUT), 1);
        tick(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) tick(1'b0, '0, 1'b0, 1'b0);
        do_reset();
        check("t6_rst_busy", int'(fl_if.fFL_busy_OUT), 0);
        check("t6_rst_count", int'(fl_if.fFL_count_OUT), 32);
        check("t6_rst_overflow", int'(fl_if.fFL_overflow_OUT), 0);
        check("t6_rst_head", int'(fl_if.fFL_popId_OUT), 32);
        tick(1'b0, '0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
